clock_set_ctrl: RTL and testbench
=================================

Name: clock_set_ctrl

Overview:
Time-set controller for the real-time clock datapath (hour/minute/second up-counters). It sequences a user edit session from three synchronous push-buttons: it freezes the clock, lets the user step hours, minutes and seconds in a shadow register, then commits the edited time with a single-cycle parallel-load strobe. It sits between the button inputs and the clock counter chain; the counters consume run_en and load/load_*.

Parameters:
REPEAT_DELAY, 50, ticks a held inc/dec must stay high before auto-repeat starts (0.5 s at 100 Hz tick)
REPEAT_RATE, 10, ticks between auto-repeat steps while held
TIMEOUT, 1000, ticks without any button edge in a set state before aborting to RUN (10 s)
BLINK_HALF, 25, ticks per half-period of the blink output

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
tick  in  1  one-cycle pulse per centisecond, from the centisecond counter wrap
btn_mode  in  1  mode button, synchronous level, active-high
btn_inc  in  1  increment button, synchronous level, active-high
btn_dec  in  1  decrement button, synchronous level, active-high
cur_hora  in  5  current clock hours, 0..23
cur_min  in  6  current clock minutes, 0..59
cur_seg  in  6  current clock seconds, 0..59
run_en  out  1  1 = clock counters run; 0 = frozen
load  out  1  one-cycle strobe: counters load load_*, centiseconds clear
load_hora  out  5  shadow hours
load_min  out  6  shadow minutes
load_seg  out  6  shadow seconds
edit_field  out  2  0 RUN, 1 hours, 2 minutes, 3 seconds
blink  out  1  display blink for the field under edit

Behaviour:
- Clock clk; reset asynchronous, active-low. Reset: state RUN, run_en=1, load=0, load_*=0, edit_field=0, blink=0; edge-detect registers, repeat, timeout and blink counters all 0.
- Edge detect: each button registered once; edge = btn & ~btn_prev. A button held through reset release produces an edge on its first high cycle.
- States (encoding = edit_field): RUN=0, SET_H=1, SET_M=2, SET_S=3. run_en = (state==RUN), decoded from the state register.
- RUN: mode edge -> shadow <= cur_*, state SET_H. Next cycle run_en=0. inc/dec are ignored.
- SET_H -> SET_M -> SET_S on mode edge. SET_S mode edge -> state RUN with load=1 for exactly that next cycle; load_* hold the shadow value. run_en returns to 1 in the same cycle as load.
- Field step in SET_x, applied to that field only: an inc edge adds 1 and wraps 23->0 (hours) or 59->0 (min/sec). A dec edge subtracts 1 and wraps 0->23 or 0->59. Result is visible the cycle after the edge.
- Priority in the same cycle: mode edge beats inc/dec, so the step is discarded. inc and dec both active: no step, and the repeat counter resets.
- Auto-repeat while exactly one of inc/dec is held at level in a set state:
  - the repeat counter counts ticks from the edge;
  - after REPEAT_DELAY ticks, one step is made, then one step every REPEAT_RATE ticks;
  - release or a state change clears the counter.
  Auto-repeat steps do not count as edges for the timeout.
- Timeout: the counter clears on any button edge and on entry to SET_H, and counts ticks in set states. On reaching TIMEOUT: state RUN, no load, shadow discarded, and the clock resumes from its frozen value.
- Blink: 0 in RUN. In set states it toggles every BLINK_HALF ticks and restarts at 1 on each state entry.
- load_* always reflect the shadow and are valid only while load=1.
- Counter widths are sized by the team to hold their parameter values. The tick count saturates and never wraps.

Test Plan:
- Reset asserted mid-edit (SET_M, shadow min=17) -> immediately run_en=1, edit_field=0, load=0, load_*=0, blink=0.
- cur=12:34:56, mode edge -> edit_field=1, run_en=0 next cycle. Then mode, mode, mode -> one-cycle load with load_hora=12, load_min=34, load_seg=56, and run_en=1.
- SET_H with shadow 23, inc edge -> 0. Then dec edge -> 23. SET_S with shadow 0, dec edge -> 59.
- SET_M, inc held 80 ticks (REPEAT_DELAY=50, REPEAT_RATE=10) -> 1 edge step + steps at ticks 50, 60, 70, 80, so min goes 10 -> 15.
- Mode and inc edges in the same cycle in SET_H (hours=5) -> edit_field=2, hours stays 5. inc and dec in the same cycle -> no change.
- SET_S, no edges for 1000 ticks -> edit_field=0, run_en=1, load never pulses. Any edge at tick 999 restarts the count.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: time-set controller for the real-time clock datapath.
// It freezes the hour/minute/second counters, lets the user edit a shadow
// copy of the time with three push-buttons, and then commits the edit with a
// single-cycle parallel-load strobe.
//
// Ports:
//   clk, reset        system clock, asynchronous active-low reset
//   tick              one-cycle pulse per centisecond
//   btn_mode/inc/dec  synchronous active-high button levels
//   cur_hora/min/seg  current clock time (frozen while editing)
//   run_en            1 = clock counters run, 0 = frozen
//   load              one-cycle strobe: counters take load_*
//   load_hora/min/seg shadow time, meaningful only while load=1
//   edit_field        state register: 0 RUN, 1 hours, 2 minutes, 3 seconds
//   blink             blink enable for the field under edit
//
// Handshake: there is no valid/ready pair here. load is a single-cycle
// strobe that the counters must accept unconditionally in that cycle.
module clock_set_ctrl #(
   parameter int REPEAT_DELAY = 50,
   parameter int REPEAT_RATE  = 10,
   parameter int TIMEOUT      = 1000,
   parameter int BLINK_HALF   = 25
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       btn_dec,
   input  logic [4:0] cur_hora,
   input  logic [5:0] cur_min,
   input  logic [5:0] cur_seg,
   output logic       run_en,
   output logic       load,
   output logic [4:0] load_hora,
   output logic [5:0] load_min,
   output logic [5:0] load_seg,
   output logic [1:0] edit_field,
   output logic       blink
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      SET_H = 2'd1,
      SET_M = 2'd2,
      SET_S = 2'd3
   } state_t;

   localparam int RW = (REPEAT_DELAY < 2) ? 1 : $clog2(REPEAT_DELAY + 1);
   localparam int TW = (TIMEOUT < 2)      ? 1 : $clog2(TIMEOUT + 1);
   localparam int BW = (BLINK_HALF < 2)   ? 1 : $clog2(BLINK_HALF + 1);

   state_t        state;
   logic          mode_prev, inc_prev, dec_prev;
   logic [RW-1:0] rep_cnt;
   logic [TW-1:0] to_cnt;
   logic [BW-1:0] blink_cnt;
   logic [4:0]    sh_hora;
   logic [5:0]    sh_min, sh_seg;

   logic mode_e, inc_e, dec_e, any_e;
   logic one_held, auto_step, step_up, step_dn, timeout_hit;

   // Wrapping +/-1 on a field whose legal range is 0..max.
   function automatic logic [5:0] wrap_step(input logic [5:0] v,
                                            input logic [5:0] max,
                                            input logic       up);
      if (up) wrap_step = (v == max)   ? 6'd0 : v + 6'd1;
      else    wrap_step = (v == 6'd0)  ? max  : v - 6'd1;
   endfunction

   assign mode_e   = btn_mode & ~mode_prev;
   assign inc_e    = btn_inc  & ~inc_prev;
   assign dec_e    = btn_dec  & ~dec_prev;
   assign any_e    = mode_e | inc_e | dec_e;
   assign one_held = btn_inc ^ btn_dec;

   // Repeat step fires on the tick that brings the counter to REPEAT_DELAY;
   // the counter is then rewound by REPEAT_RATE so later steps are RATE apart.
   assign auto_step = one_held & ~inc_e & ~dec_e & tick &
                      (rep_cnt == RW'(REPEAT_DELAY - 1));
   // Holding both buttons blocks stepping; a mode edge discards the step.
   assign step_up = ~mode_e & ~btn_dec & (inc_e | (auto_step & btn_inc));
   assign step_dn = ~mode_e & ~btn_inc & (dec_e | (auto_step & btn_dec));
   assign timeout_hit = tick & ~any_e & (to_cnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= RUN;
         mode_prev <= 1'b0;
         inc_prev  <= 1'b0;
         dec_prev  <= 1'b0;
         rep_cnt   <= '0;
         to_cnt    <= '0;
         blink_cnt <= '0;
         blink     <= 1'b0;
         load      <= 1'b0;
         sh_hora   <= '0;
         sh_min    <= '0;
         sh_seg    <= '0;
      end else begin
         mode_prev <= btn_mode;
         inc_prev  <= btn_inc;
         dec_prev  <= btn_dec;
         load      <= 1'b0;
         if (state == RUN) begin
            rep_cnt   <= '0;
            to_cnt    <= '0;
            blink_cnt <= '0;
            blink     <= 1'b0;
            if (mode_e) begin
               sh_hora <= cur_hora;
               sh_min  <= cur_min;
               sh_seg  <= cur_seg;
               state   <= SET_H;
               blink   <= 1'b1;
            end
         end else if (mode_e) begin
            rep_cnt   <= '0;
            to_cnt    <= '0;
            blink_cnt <= '0;
            blink     <= (state != SET_S);
            case (state)
               SET_H:   state <= SET_M;
               SET_M:   state <= SET_S;
               default: begin
                  state <= RUN;
                  load  <= 1'b1;
               end
            endcase
         end else if (timeout_hit) begin
            // Abort: shadow is simply never loaded, counters resume as-is.
            state     <= RUN;
            rep_cnt   <= '0;
            to_cnt    <= '0;
            blink_cnt <= '0;
            blink     <= 1'b0;
         end else begin
            if (step_up || step_dn) begin
               case (state)
                  SET_H:   sh_hora <= 5'(wrap_step({1'b0, sh_hora}, 6'd23, step_up));
                  SET_M:   sh_min  <= wrap_step(sh_min, 6'd59, step_up);
                  default: sh_seg  <= wrap_step(sh_seg, 6'd59, step_up);
               endcase
            end
            if (!one_held || inc_e || dec_e)
               rep_cnt <= '0;
            else if (tick)
               rep_cnt <= auto_step ? RW'(REPEAT_DELAY - REPEAT_RATE)
                                    : rep_cnt + 1'b1;
            if (any_e)
               to_cnt <= '0;
            else if (tick)
               to_cnt <= to_cnt + 1'b1;
            if (tick) begin
               if (blink_cnt == BW'(BLINK_HALF - 1)) begin
                  blink_cnt <= '0;
                  blink     <= ~blink;
               end else begin
                  blink_cnt <= blink_cnt + 1'b1;
               end
            end
         end
      end
   end

   assign run_en     = (state == RUN);
   assign edit_field = state;
   assign load_hora  = sh_hora;
   assign load_min   = sh_min;
   assign load_seg   = sh_seg;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with default parameters.
module tb_clock_set_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       tick = 1'b0;
   logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
   logic [4:0] cur_hora = '0;
   logic [5:0] cur_min = '0, cur_seg = '0;
   logic       run_en, load, blink;
   logic [4:0] load_hora;
   logic [5:0] load_min, load_seg;
   logic [1:0] edit_field;

   int checks = 0;
   int errors = 0;
   logic mon = 1'b0;
   logic load_seen = 1'b0;

   clock_set_ctrl dut (
      .clk(clk), .reset(reset), .tick(tick),
      .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
      .cur_hora(cur_hora), .cur_min(cur_min), .cur_seg(cur_seg),
      .run_en(run_en), .load(load),
      .load_hora(load_hora), .load_min(load_min), .load_seg(load_seg),
      .edit_field(edit_field), .blink(blink)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (mon && load) load_seen <= 1'b1;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   // One idle cycle, then buttons high across one edge, then released.
   task automatic pulse(input logic m, input logic i, input logic d);
      cyc();
      btn_mode = m; btn_inc = i; btn_dec = d;
      cyc();
      btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_run_en", run_en, 1);
      chk("rst_field", edit_field, 0);
      chk("rst_load", load, 0);
      chk("rst_blink", blink, 0);
      cycles(2);
      reset = 1'b1;
      cyc();

      // Full edit session with commit
      cur_hora = 5'd12; cur_min = 6'd34; cur_seg = 6'd56;
      pulse(1, 0, 0);
      chk("enter_field", edit_field, 1);
      chk("enter_run_en", run_en, 0);
      chk("enter_blink", blink, 1);
      pulse(1, 0, 0);
      chk("to_min", edit_field, 2);
      pulse(1, 0, 0);
      chk("to_sec", edit_field, 3);
      pulse(1, 0, 0);
      chk("commit_load", load, 1);
      chk("commit_run_en", run_en, 1);
      chk("commit_field", edit_field, 0);
      chk("commit_hora", load_hora, 12);
      chk("commit_min", load_min, 34);
      chk("commit_seg", load_seg, 56);
      cyc();
      chk("load_one_cycle", load, 0);

      // Wrap tests: inc/dec in RUN ignored first
      cur_hora = 5'd23; cur_min = 6'd10; cur_seg = 6'd0;
      pulse(0, 1, 0);
      chk("run_inc_ignored", edit_field, 0);
      pulse(1, 0, 0);
      chk("wrap_h_start", load_hora, 23);
      pulse(0, 1, 0);
      chk("wrap_h_inc", load_hora, 0);
      pulse(0, 0, 1);
      chk("wrap_h_dec", load_hora, 23);
      pulse(1, 0, 0);
      chk("rep_field", edit_field, 2);

      // Auto-repeat on minutes: edge step + steps at ticks 50,60,70,80
      cyc();
      btn_inc = 1'b1;
      cyc();
      chk("rep_edge", load_min, 11);
      tick = 1'b1;
      cycles(49);
      chk("rep_t49", load_min, 11);
      cyc();
      chk("rep_t50", load_min, 12);
      cycles(30);
      chk("rep_t80", load_min, 15);
      tick = 1'b0;
      btn_inc = 1'b0;
      cycles(3);
      chk("rep_release", load_min, 15);
      chk("rep_hora_kept", load_hora, 23);

      // Seconds 0 -> 59 on dec
      pulse(1, 0, 0);
      chk("sec_field", edit_field, 3);
      pulse(0, 0, 1);
      chk("wrap_s_dec", load_seg, 59);

      // Timeout with restart by an edge at 999 ticks
      mon = 1'b1;
      tick = 1'b1;
      cycles(999);
      tick = 1'b0;
      chk("to_999", edit_field, 3);
      pulse(0, 1, 0);
      chk("to_edge_step", load_seg, 0);
      tick = 1'b1;
      cycles(999);
      chk("to_restart_999", edit_field, 3);
      cyc();
      tick = 1'b0;
      chk("to_field", edit_field, 0);
      chk("to_run_en", run_en, 1);
      cycles(2);
      chk("to_no_load", load_seen, 0);
      mon = 1'b0;

      // Priority: mode beats inc; inc+dec together gives no step
      cur_hora = 5'd5; cur_min = 6'd17; cur_seg = 6'd30;
      pulse(1, 0, 0);
      chk("pri_h_start", load_hora, 5);
      pulse(1, 1, 0);
      chk("pri_mode_field", edit_field, 2);
      chk("pri_hora_kept", load_hora, 5);
      pulse(0, 1, 1);
      chk("pri_both_min", load_min, 17);

      // Blink in SET_M: entered at 1, toggles after 25 ticks
      chk("blink_entry", blink, 1);
      tick = 1'b1;
      cycles(24);
      chk("blink_t24", blink, 1);
      cyc();
      chk("blink_t25", blink, 0);
      tick = 1'b0;

      // Asynchronous reset mid-edit
      #2;
      reset = 1'b0;
      #1;
      chk("amid_run_en", run_en, 1);
      chk("amid_field", edit_field, 0);
      chk("amid_load", load, 0);
      chk("amid_min", load_min, 0);
      chk("amid_hora", load_hora, 0);
      chk("amid_blink", blink, 0);
      cycles(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
